// File: rtl/ddr_timing_pkg.sv
// ddr_timing_pkg: shared types, timing-register indices and reset defaults for the bank timing tracker
package ddr_timing_pkg;
  typedef enum logic [2:0] {IDLE, ACTIVATING, ACTIVE, READING, WRITING, PRECHARGING, REFRESHING} bank_state_t;
  typedef enum logic [3:0] {NOP, ACT, RD, RDA, WR, WRA, PRE, PREA, REF} cmd_t;
  localparam int T_CL = 0, T_RCD = 1, T_RP = 2, T_RFC = 3, T_WR = 4, T_RTP = 5;
  localparam int T_CWL = 6, T_RAS = 7, T_RRD_S = 8, T_RRD_L = 9, T_REFI = 10, T_NUM = 11;
  localparam int DEF_CL = 17, DEF_RCD = 17, DEF_RP = 17, DEF_RFC = 34, DEF_WR = 14, DEF_RTP = 7;
  localparam int DEF_CWL = 10, DEF_RAS = 32, DEF_RRD_S = 4, DEF_RRD_L = 6, DEF_REFI = 9360;
  function automatic int timing_default(input int idx);
    return idx == T_CL ? DEF_CL : idx == T_RCD ? DEF_RCD : idx == T_RP ? DEF_RP :
           idx == T_RFC ? DEF_RFC : idx == T_WR ? DEF_WR : idx == T_RTP ? DEF_RTP :
           idx == T_CWL ? DEF_CWL : idx == T_RAS ? DEF_RAS : idx == T_RRD_S ? DEF_RRD_S :
           idx == T_RRD_L ? DEF_RRD_L : DEF_REFI;
  endfunction
endpackage

// File: rtl/bank_timer.sv
// bank_timer: one bank's state machine with its occupancy timer and tRAS timer
module bank_timer
  import ddr_timing_pkg::*;
#(parameter int TW = 16) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          go_act,
  input  logic          go_rd,
  input  logic          go_wr,
  input  logic          go_pre,
  input  logic          go_ref,
  input  logic          auto_pre,
  input  logic [TW-1:0] d_rcd,
  input  logic [TW-1:0] d_ras,
  input  logic [TW-1:0] d_rd,
  input  logic [TW-1:0] d_rtp,
  input  logic [TW-1:0] d_wr,
  input  logic [TW-1:0] d_rp,
  input  logic [TW-1:0] d_rfc,
  output logic [2:0]    state,
  output logic          busy,
  output logic          idle_ok,
  output logic          active_ok,
  output logic          pre_ok
);
  bank_state_t cur, nxt, eff;
  logic [TW-1:0] timer, timer_n, ras, ras_n, rd_max, rda_d;
  logic auto_q, auto_n, expire;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur <= IDLE;
      timer <= '0;
      ras <= '0;
      auto_q <= 1'b0;
    end else begin
      cur <= nxt;
      timer <= timer_n;
      ras <= ras_n;
      auto_q <= auto_n;
    end
  // a timer at 1 finishes on this edge, so commands already see the state that follows
  always_comb begin
    expire = timer == TW'(1);
    eff = !expire ? cur :
          cur == ACTIVATING ? ACTIVE :
          (cur == READING || cur == WRITING) ? (auto_q ? PRECHARGING : ACTIVE) :
          (cur == PRECHARGING || cur == REFRESHING) ? IDLE : cur;
    rd_max = d_rd > d_rtp ? d_rd : d_rtp;
    rda_d = rd_max > ras ? rd_max : ras;
    nxt = eff;
    timer_n = (expire && eff == PRECHARGING) ? d_rp : timer != '0 ? timer - 1'b1 : '0;
    ras_n = ras != '0 ? ras - 1'b1 : '0;
    auto_n = auto_q;
    if (go_act) begin
      nxt = ACTIVATING;
      timer_n = d_rcd;
      ras_n = d_ras;
    end else if (go_rd) begin
      nxt = READING;
      timer_n = auto_pre ? rda_d : d_rd;
      auto_n = auto_pre;
    end else if (go_wr) begin
      nxt = WRITING;
      timer_n = d_wr;
      auto_n = auto_pre;
    end else if (go_pre) begin
      nxt = PRECHARGING;
      timer_n = d_rp;
    end else if (go_ref) begin
      nxt = REFRESHING;
      timer_n = d_rfc;
    end
  end
  assign state = cur;
  assign busy = timer != '0;
  assign idle_ok = eff == IDLE;
  assign active_ok = eff == ACTIVE;
  assign pre_ok = eff == ACTIVE && ras <= TW'(1);
endmodule

// File: rtl/bank_timing_tracker.sv
// bank_timing_tracker: per-bank DDR timing model with command legality, tRRD, tREFI and cfg registers
module bank_timing_tracker
  import ddr_timing_pkg::*;
#(
  parameter int BL = 8,
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int TW = 16,
  localparam int NG = 2 ** BGWIDTH,
  localparam int NB = 2 ** BAWIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  input  logic [3:0]                    cmd,
  input  logic [BGWIDTH-1:0]            bg,
  input  logic [BAWIDTH-1:0]            ba,
  input  logic                          cfg_we,
  input  logic [3:0]                    cfg_addr,
  input  logic [TW-1:0]                 cfg_wdata,
  output logic [NG-1:0][NB-1:0][2:0]    bank_state,
  output logic [NG-1:0][NB-1:0]         bank_busy,
  output logic                          cmd_err,
  output logic                          refresh_due
);
  function automatic logic [TW-1:0] nz(input logic [TW-1:0] v);
    return v == '0 ? TW'(1) : v;
  endfunction
  cmd_t c;
  logic [TW-1:0] tim [T_NUM];
  logic [TW-1:0] cnt_l [NG];
  logic [TW-1:0] cnt_s [NG];
  logic [TW-1:0] refi;
  logic [NG-1:0][NB-1:0] idle_ok, active_ok, pre_ok, go_act, go_rd, go_wr, go_pre, go_ref;
  logic tgt_idle, tgt_active, tgt_pre, rrd_ok, legal, acc, auto_pre, ref_acc;
  logic [TW-1:0] d_rcd, d_ras, d_rd, d_rtp, d_wr, d_rp, d_rfc;
  assign c = cmd_t'(cmd);
  assign auto_pre = c == RDA || c == WRA;
  assign ref_acc = acc && c == REF;
  assign d_rcd = nz(tim[T_RCD]);
  assign d_ras = nz(tim[T_RAS]);
  assign d_rd = nz(tim[T_CL] + TW'(BL / 2));
  assign d_rtp = nz(tim[T_RTP]);
  assign d_wr = nz(tim[T_CWL] + tim[T_WR] + TW'(BL / 2));
  assign d_rp = nz(tim[T_RP]);
  assign d_rfc = nz(tim[T_RFC]);
  always_comb begin
    tgt_idle = idle_ok[bg][ba];
    tgt_active = active_ok[bg][ba];
    tgt_pre = pre_ok[bg][ba];
    rrd_ok = 1'b1;
    for (int g = 0; g < NG; g++)
      rrd_ok = rrd_ok && (g == int'(bg) ? cnt_l[g] <= TW'(1) : cnt_s[g] <= TW'(1));
    legal = c == NOP ? 1'b1 :
            c == ACT ? tgt_idle && rrd_ok :
            (c == RD || c == RDA || c == WR || c == WRA) ? tgt_active :
            c == PRE ? tgt_idle || tgt_pre :
            c == PREA ? &(idle_ok | pre_ok) :
            c == REF ? &idle_ok : 1'b0;
    acc = cmd_valid && legal;
    go_act = '0;
    go_rd = '0;
    go_wr = '0;
    go_act[bg][ba] = acc && c == ACT;
    go_rd[bg][ba] = acc && (c == RD || c == RDA);
    go_wr[bg][ba] = acc && (c == WR || c == WRA);
    go_pre = acc && c == PREA ? pre_ok : '0;
    go_pre[bg][ba] = go_pre[bg][ba] | (acc && c == PRE && tgt_pre);
    go_ref = ref_acc ? '1 : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < T_NUM; i++) tim[i] <= TW'(timing_default(i));
      for (int g = 0; g < NG; g++) begin
        cnt_l[g] <= '0;
        cnt_s[g] <= '0;
      end
      refi <= TW'(DEF_REFI);
      refresh_due <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr < 4'(T_NUM)) tim[cfg_addr] <= cfg_wdata;
      for (int g = 0; g < NG; g++) begin
        cnt_l[g] <= cnt_l[g] != '0 ? cnt_l[g] - 1'b1 : '0;
        cnt_s[g] <= cnt_s[g] != '0 ? cnt_s[g] - 1'b1 : '0;
      end
      if (acc && c == ACT) begin
        cnt_l[bg] <= nz(tim[T_RRD_L]);
        cnt_s[bg] <= nz(tim[T_RRD_S]);
      end
      refi <= ref_acc ? nz(tim[T_REFI]) : refi != '0 ? refi - 1'b1 : '0;
      refresh_due <= !ref_acc && (refresh_due || refi == TW'(1));
      cmd_err <= cmd_valid && !legal;
    end
  for (genvar g = 0; g < NG; g++) begin : gg
    for (genvar b = 0; b < NB; b++) begin : gb
      bank_timer #(.TW(TW)) u_bank (
        .clk(clk), .reset_n(reset_n),
        .go_act(go_act[g][b]), .go_rd(go_rd[g][b]), .go_wr(go_wr[g][b]),
        .go_pre(go_pre[g][b]), .go_ref(go_ref[g][b]), .auto_pre(auto_pre),
        .d_rcd(d_rcd), .d_ras(d_ras), .d_rd(d_rd), .d_rtp(d_rtp),
        .d_wr(d_wr), .d_rp(d_rp), .d_rfc(d_rfc),
        .state(bank_state[g][b]), .busy(bank_busy[g][b]),
        .idle_ok(idle_ok[g][b]), .active_ok(active_ok[g][b]), .pre_ok(pre_ok[g][b])
      );
    end
  end
endmodule

// File: tb/tb_bank_timing_tracker.sv
// tb_bank_timing_tracker: directed scenarios with a cmd_err scoreboard and state checks
module tb_bank_timing_tracker;
  import ddr_timing_pkg::*;
  logic clk = 1'b0, reset_n, cmd_valid, cfg_we, cmd_err, refresh_due;
  logic [3:0] cmd, cfg_addr;
  logic [1:0] bg, ba;
  logic [15:0] cfg_wdata;
  logic [3:0][3:0][2:0] bank_state;
  logic [3:0][3:0] bank_busy;
  int tests = 0, fails = 0;
  logic err_q[$];
  bank_timing_tracker dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd), .bg(bg), .ba(ba),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .bank_state(bank_state), .bank_busy(bank_busy), .cmd_err(cmd_err), .refresh_due(refresh_due)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end
  function automatic logic [63:0] all_st(input logic [2:0] s);
    logic [63:0] r = '0;
    for (int i = 0; i < 16; i++) r[i*3 +: 3] = s;
    return r;
  endfunction
  function automatic logic [2:0] st(input int g, input int b);
    return bank_state[g][b];
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic issue(input string tag, input logic [3:0] c, input int g, input int b, input logic e);
    cmd_valid = 1'b1;
    cmd = c;
    bg = 2'(g);
    ba = 2'(b);
    err_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
    cmd = 4'(NOP);
    cfg_we = 1'b0;
    chk(tag, 64'(cmd_err), 64'(err_q.pop_front()));
  endtask
  task automatic reset_pulse();
    reset_n = 1'b0;
    #2;
    chk("rst_state", 64'(bank_state), all_st(IDLE));
    chk("rst_busy", 64'(bank_busy), 64'(0));
    chk("rst_err", 64'(cmd_err), 64'(0));
    chk("rst_due", 64'(refresh_due), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    cmd_valid = 1'b0; cmd = 4'(NOP); bg = 2'd0; ba = 2'd0;
    cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 16'd0;
    reset_pulse();
    issue("t1_act", ACT, 0, 0, 1'b0);
    chk("t1_activating", 64'(st(0, 0)), 64'(ACTIVATING));
    chk("t1_busy", 64'(bank_busy[0][0]), 64'(1));
    idle(15);
    issue("t1_rd_early", RD, 0, 0, 1'b1);
    chk("t1_still_activating", 64'(st(0, 0)), 64'(ACTIVATING));
    issue("t1_rd", RD, 0, 0, 1'b0);
    chk("t1_reading", 64'(st(0, 0)), 64'(READING));
    idle(20);
    chk("t1_reading_last", 64'(st(0, 0)), 64'(READING));
    idle(1);
    chk("t1_active", 64'(st(0, 0)), 64'(ACTIVE));
    chk("t1_not_busy", 64'(bank_busy[0][0]), 64'(0));
    issue("t1_pre", PRE, 0, 0, 1'b0);
    idle(16);
    chk("t1_precharging", 64'(st(0, 0)), 64'(PRECHARGING));
    idle(1);
    chk("t1_idle", 64'(st(0, 0)), 64'(IDLE));
    issue("t2_act", ACT, 0, 0, 1'b0);
    idle(19);
    issue("t2_pre_tras", PRE, 0, 0, 1'b1);
    chk("t2_active_kept", 64'(st(0, 0)), 64'(ACTIVE));
    idle(11);
    issue("t2_pre_ok", PRE, 0, 0, 1'b0);
    chk("t2_precharging", 64'(st(0, 0)), 64'(PRECHARGING));
    idle(16);
    chk("t2_precharging_last", 64'(st(0, 0)), 64'(PRECHARGING));
    idle(1);
    chk("t2_idle", 64'(st(0, 0)), 64'(IDLE));
    issue("t2_pre_idle_noop", PRE, 3, 3, 1'b0);
    chk("t2_noop_state", 64'(st(3, 3)), 64'(IDLE));
    issue("t3_act00", ACT, 0, 0, 1'b0);
    idle(2);
    issue("t3_rrd_l_err", ACT, 0, 1, 1'b1);
    chk("t3_01_idle", 64'(st(0, 1)), 64'(IDLE));
    issue("t3_rrd_s_ok", ACT, 1, 0, 1'b0);
    idle(4);
    issue("t3_rrd_l_err2", ACT, 1, 1, 1'b1);
    issue("t3_rrd_l_ok", ACT, 1, 1, 1'b0);
    chk("t3_11_activating", 64'(st(1, 1)), 64'(ACTIVATING));
    idle(10);
    cfg_we = 1'b1; cfg_addr = 4'(T_RCD); cfg_wdata = 16'd5;
    issue("t4_act22_cfg", ACT, 2, 2, 1'b0);
    idle(4);
    issue("t4_act33", ACT, 3, 3, 1'b0);
    idle(4);
    chk("t4_33_activating", 64'(st(3, 3)), 64'(ACTIVATING));
    idle(1);
    chk("t4_33_active", 64'(st(3, 3)), 64'(ACTIVE));
    chk("t4_22_old_rcd", 64'(st(2, 2)), 64'(ACTIVATING));
    idle(7);
    chk("t4_22_active", 64'(st(2, 2)), 64'(ACTIVE));
    reset_pulse();
    idle(9359);
    chk("t5_due_early", 64'(refresh_due), 64'(0));
    idle(1);
    chk("t5_due_set", 64'(refresh_due), 64'(1));
    issue("t5_act", ACT, 0, 0, 1'b0);
    idle(16);
    issue("t5_ref_busy", REF, 0, 0, 1'b1);
    chk("t5_due_kept", 64'(refresh_due), 64'(1));
    idle(2);
    issue("t5_prea_tras", PREA, 0, 0, 1'b1);
    chk("t5_prea_nochange", 64'(st(0, 0)), 64'(ACTIVE));
    idle(11);
    issue("t5_prea", PREA, 0, 0, 1'b0);
    chk("t5_prea_precharging", 64'(st(0, 0)), 64'(PRECHARGING));
    chk("t5_prea_idle_kept", 64'(st(2, 1)), 64'(IDLE));
    idle(16);
    issue("t5_ref", REF, 0, 0, 1'b0);
    chk("t5_due_clear", 64'(refresh_due), 64'(0));
    chk("t5_all_refreshing", 64'(bank_state), all_st(REFRESHING));
    chk("t5_all_busy", 64'(bank_busy), 64'(16'hffff));
    idle(33);
    chk("t5_refresh_last", 64'(bank_state), all_st(REFRESHING));
    idle(1);
    chk("t5_all_idle", 64'(bank_state), all_st(IDLE));
    cfg_we = 1'b1; cfg_addr = 4'(T_RCD); cfg_wdata = 16'd5;
    tick();
    cfg_we = 1'b0;
    issue("t6_act", ACT, 1, 2, 1'b0);
    idle(4);
    issue("t6_wr", WR, 1, 2, 1'b0);
    chk("t6_writing", 64'(st(1, 2)), 64'(WRITING));
    idle(10);
    chk("t6_writing_mid", 64'(st(1, 2)), 64'(WRITING));
    reset_pulse();
    issue("t6_act_after_rst", ACT, 0, 0, 1'b0);
    idle(16);
    chk("t6_rcd_default", 64'(st(0, 0)), 64'(ACTIVATING));
    idle(1);
    chk("t6_active", 64'(st(0, 0)), 64'(ACTIVE));
    chk("sb_empty", 64'(err_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
